// File: rtl/sp_pkg.sv
// Shared constants and state encoding for the serial_parallel receive stage.
package sp_pkg;

    localparam int BYTE_W = 8;
    localparam logic [BYTE_W-1:0] COM_DEFAULT = 8'hBC;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        LOCK   = 2'd1,
        ACTIVE = 2'd2
    } sp_state_t;

endpackage

// File: rtl/sp_com_detect.sv
// Serial shift register with a comparator that flags the COM symbol in the
// sliding 8-bit window formed by the stored bits plus the bit arriving now.
module sp_com_detect
    import sp_pkg::*;
#(
    parameter logic [BYTE_W-1:0] COM_SYMBOL = COM_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              data_in_serial,
    output logic [BYTE_W-1:0] candidate,
    output logic              is_com
);

    logic [BYTE_W-1:0] shift_reg;

    // Candidate includes the current bit so a byte is judged on the edge that samples its LSB.
    assign candidate = {shift_reg[BYTE_W-2:0], data_in_serial};
    assign is_com    = (candidate == COM_SYMBOL);

    always_ff @(posedge clk) begin
        if (reset) begin
            shift_reg <= '0;
        end else begin
            shift_reg <= candidate;
        end
    end

endmodule

// File: rtl/serial_parallel.sv
// Serial-to-parallel receiver: hunts COM alignment, locks after COM_COUNT
// aligned COMs, then emits non-COM bytes. Optional SP_BYTE_CNT_EN adds rx_byte_cnt.
module serial_parallel
    import sp_pkg::*;
#(
    parameter logic [BYTE_W-1:0] COM_SYMBOL = COM_DEFAULT,
    parameter int                COM_COUNT  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              data_in_serial,
    output logic [BYTE_W-1:0] data_out_8b,
    output logic              valid_out,
    output logic              active
`ifdef SP_BYTE_CNT_EN
    ,
    output logic [15:0]       rx_byte_cnt
`endif
);

    localparam logic [3:0] COM_TARGET = 4'(COM_COUNT);

    sp_state_t         state;
    logic [2:0]        bit_cnt;
    logic [3:0]        com_cnt;
    logic [BYTE_W-1:0] candidate;
    logic              is_com;
    logic              boundary;

    sp_com_detect #(
        .COM_SYMBOL(COM_SYMBOL)
    ) u_com_detect (
        .clk           (clk),
        .reset         (reset),
        .data_in_serial(data_in_serial),
        .candidate     (candidate),
        .is_com        (is_com)
    );

    assign boundary = (bit_cnt == 3'd7);

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= HUNT;
            bit_cnt     <= 3'd0;
            com_cnt     <= 4'd0;
            data_out_8b <= '0;
            valid_out   <= 1'b0;
            active      <= 1'b0;
        end else begin
            case (state)
                HUNT: begin
                    if (is_com) begin
                        bit_cnt <= 3'd0;
                        com_cnt <= 4'd1;
                        if (COM_COUNT == 1) begin
                            state  <= ACTIVE;
                            active <= 1'b1;
                        end else begin
                            state <= LOCK;
                        end
                    end
                end
                LOCK: begin
                    bit_cnt <= bit_cnt + 3'd1;
                    if (boundary) begin
                        if (is_com) begin
                            com_cnt <= com_cnt + 4'd1;
                            if (com_cnt + 4'd1 == COM_TARGET) begin
                                state  <= ACTIVE;
                                active <= 1'b1;
                            end
                        end else begin
                            state   <= HUNT;
                            com_cnt <= 4'd0;
                        end
                    end
                end
                ACTIVE: begin
                    bit_cnt <= bit_cnt + 3'd1;
                    if (boundary) begin
                        data_out_8b <= candidate;
                        valid_out   <= !is_com;
                    end
                end
                default: begin
                    state <= HUNT;
                end
            endcase
        end
    end

`ifdef SP_BYTE_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_byte_cnt <= 16'd0;
        end else if (state == ACTIVE && boundary && !is_com && rx_byte_cnt != 16'hFFFF) begin
            rx_byte_cnt <= rx_byte_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_serial_parallel.sv
// Self-checking bench for serial_parallel: directed scenarios plus random bytes,
// compared every cycle against a bit-level behavioural reference model.
module tb_serial_parallel;

    localparam logic [7:0] COM = 8'hBC;
    localparam int         NCOM = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       data_in_serial = 1'b0;
    logic [7:0] data_out_8b;
    logic       valid_out;
    logic       active;
`ifdef SP_BYTE_CNT_EN
    logic [15:0] rx_byte_cnt;
`endif

    int compared = 0;
    int mismatched = 0;

    // Reference model: window of recent bits, alignment phase and received-byte summary.
    int         m_win;
    bit         m_aligned;
    int         m_phase;
    int         m_coms;
    bit         m_act;
    logic [7:0] m_data;
    bit         m_vld;
    int         m_bytes;

    serial_parallel dut (
        .clk           (clk),
        .reset         (reset),
        .data_in_serial(data_in_serial),
        .data_out_8b   (data_out_8b),
        .valid_out     (valid_out),
        .active        (active)
`ifdef SP_BYTE_CNT_EN
        ,
        .rx_byte_cnt   (rx_byte_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_win = 0; m_aligned = 0; m_phase = 0; m_coms = 0;
        m_act = 0; m_data = 8'h00; m_vld = 0; m_bytes = 0;
    endtask

    task automatic model_bit(input bit b);
        m_win = ((m_win << 1) | int'(b)) & 255;
        if (!m_aligned) begin
            if (m_win == int'(COM)) begin
                m_aligned = 1; m_phase = 0; m_coms = 1;
                if (NCOM == 1) m_act = 1;
            end
        end else begin
            m_phase++;
            if (m_phase == 8) begin
                m_phase = 0;
                if (!m_act) begin
                    if (m_win == int'(COM)) begin
                        m_coms++;
                        if (m_coms >= NCOM) m_act = 1;
                    end else begin
                        m_aligned = 0; m_coms = 0;
                    end
                end else begin
                    m_data = 8'(m_win);
                    m_vld  = (m_win != int'(COM));
                    if (m_vld && m_bytes < 65535) m_bytes++;
                end
            end
        end
    endtask

    task automatic check_all();
        check("data", 16'(data_out_8b), 16'(m_data));
        check("valid", 16'(valid_out), 16'(m_vld));
        check("active", 16'(active), 16'(m_act));
`ifdef SP_BYTE_CNT_EN
        check("bytecnt", rx_byte_cnt, 16'(m_bytes));
`endif
    endtask

    task automatic send_bit(input bit b);
        @(negedge clk);
        data_in_serial = b;
        @(posedge clk);
        #1;
        model_bit(b);
        check_all();
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) send_bit(v[i]);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        data_in_serial = 1'($urandom_range(0, 1));
        @(posedge clk);
        #1;
        model_reset();
        check_all();
        reset = 1'b0;
    endtask

    initial begin
        logic [7:0] rb;
        model_reset();

        // 1: reset then COMs; active rises exactly on the 4th COM's last bit
        do_reset();
        check("rst_data", 16'(data_out_8b), 16'h0000);
        check("rst_active", 16'(active), 16'h0000);
        for (int k = 0; k < 3; k++) send_byte(COM);
        for (int i = 7; i >= 1; i--) send_bit(COM[i]);
        check("t1_active_pre", 16'(active), 16'h0000);
        check("t1_data_pre", 16'(data_out_8b), 16'h0000);
        send_bit(COM[0]);
        check("t1_active", 16'(active), 16'h0001);
        send_byte(COM);
        send_byte(COM);
        check("t1_valid", 16'(valid_out), 16'h0000);

        // 2: 0xAA x2 then 0xAB x2
        send_byte(8'hAA);
        check("t2_aa", 16'(data_out_8b), 16'h00AA);
        check("t2_aa_v", 16'(valid_out), 16'h0001);
        send_byte(8'hAA);
        send_byte(8'hAB);
        check("t2_ab", 16'(data_out_8b), 16'h00AB);
        send_byte(8'hAB);
        check("t2_ab_v", 16'(valid_out), 16'h0001);

        // 3: misaligned start, lock after 35 bits, then 0x5A
        do_reset();
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        for (int k = 0; k < 3; k++) send_byte(COM);
        for (int i = 7; i >= 1; i--) send_bit(COM[i]);
        check("t3_active_pre", 16'(active), 16'h0000);
        send_bit(COM[0]);
        check("t3_active", 16'(active), 16'h0001);
        send_byte(8'h5A);
        check("t3_5a", 16'(data_out_8b), 16'h005A);

        // 4: broken lock returns to hunt, clean COMs recover
        do_reset();
        send_byte(COM); send_byte(COM);
        send_byte(8'h3C);
        check("t4_unlock", 16'(active), 16'h0000);
        for (int k = 0; k < 3; k++) send_byte(COM);
        check("t4_active_pre", 16'(active), 16'h0000);
        send_byte(COM);
        check("t4_active", 16'(active), 16'h0001);

        // 5: COM inside ACTIVE is delivered without valid
        send_byte(8'h12);
        check("t5_12", 16'(data_out_8b), 16'h0012);
        send_byte(COM);
        check("t5_com", 16'(data_out_8b), 16'h00BC);
        check("t5_com_v", 16'(valid_out), 16'h0000);
        check("t5_active", 16'(active), 16'h0001);
        send_byte(8'h34);
        check("t5_34_v", 16'(valid_out), 16'h0001);

        // 6: reset mid-byte while ACTIVE
        send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
        do_reset();
        check("t6_active", 16'(active), 16'h0000);
        check("t6_valid", 16'(valid_out), 16'h0000);
        check("t6_data", 16'(data_out_8b), 16'h0000);
`ifdef SP_BYTE_CNT_EN
        check("t6_cnt", rx_byte_cnt, 16'h0000);
`endif

        // Random: noise while hunting, alignment, then random payload
        for (int i = 0; i < 13; i++) send_bit(1'($urandom_range(0, 1)));
        for (int k = 0; k < NCOM; k++) send_byte(COM);
        for (int k = 0; k < 60; k++) begin
            rb = 8'($urandom_range(0, 255));
            if (k % 7 == 0) rb = COM;
            send_byte(rb);
        end
        do_reset();
        for (int k = 0; k < 40; k++) send_byte(($urandom_range(0, 3) == 0) ? COM : 8'($urandom));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
